// File: rtl/instr_queue_pkg.sv
// Shared definitions for the fetch-to-dispatch instruction queue:
// instruction/address types, the stored entry layout and the default depth.
package instr_queue_pkg;

   localparam int IQ_DEPTH = 8;

   typedef logic [31:0] instr_t;
   typedef logic [31:0] addr_t;

   typedef struct packed {
      instr_t instr;
      addr_t  pc;
      addr_t  npc;
      logic   br_taken;
   } iq_entry_t;

endpackage

// File: rtl/instr_queue_if.sv
// Fetch/dispatch side signals of the instruction queue.
//
// Handshake: a transfer happens on a rising clk edge where valid && ready are
// both 1. The producer holds its payload stable while valid is 1; ready never
// depends combinationally on valid (enq_ready is !full, deq_valid is !empty).
// flush is a single-cycle command sampled on the rising edge.
interface instr_queue_if
   import instr_queue_pkg::*;
#(
   parameter int DEPTH = IQ_DEPTH
) ();

   localparam int CW = $clog2(DEPTH) + 1;

   // Enqueue side (fetch)
   logic    enq_valid;
   logic    enq_ready;
   instr_t  enq_instr;
   addr_t   enq_pc;
   addr_t   enq_npc;
   logic    enq_br_taken;

   // Dequeue side (dispatch / decoder)
   logic    deq_valid;
   logic    deq_ready;
   instr_t  deq_instr;
   addr_t   deq_pc;
   addr_t   deq_npc;
   logic    deq_br_taken;

   // Control and status
   logic          flush;
   logic [CW-1:0] count;

   // Environment side: fetch, dispatch and redirect logic
   modport master (
      output enq_valid, enq_instr, enq_pc, enq_npc, enq_br_taken,
      output deq_ready, flush,
      input  enq_ready,
      input  deq_valid, deq_instr, deq_pc, deq_npc, deq_br_taken,
      input  count
   );

   // Queue side
   modport slave (
      input  enq_valid, enq_instr, enq_pc, enq_npc, enq_br_taken,
      input  deq_ready, flush,
      output enq_ready,
      output deq_valid, deq_instr, deq_pc, deq_npc, deq_br_taken,
      output count
   );

endinterface

// File: rtl/instr_queue_ptr_counter.sv
// Wrap-bit pointer for the instruction queue. The low bits index the buffer,
// the MSB toggles each time the index rolls over, so the counter simply runs
// modulo 2**W (= 2*DEPTH) and full/empty can be told apart.
module ptr_counter #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_aL,
   input  logic         clear,
   input  logic         inc,
   output logic [W-1:0] ptr
);

   // Pointer register: clear wins over increment
   always_ff @(posedge clk or negedge rst_aL) begin
      if (!rst_aL) begin
         ptr <= '0;
      end else if (clear) begin
         ptr <= '0;
      end else if (inc) begin
         ptr <= ptr + 1'b1;
      end
   end

endmodule

// File: rtl/instr_queue.sv
// Instruction queue between fetch and dispatch: a circular buffer of DEPTH
// entries with wrap-bit head/tail pointers. The head entry is presented
// combinationally on deq_*; new entries become visible one edge after they
// are written. No enqueue-to-dequeue bypass and no full-queue pass-through.
// DEPTH must be a power of two and at least 2.
module instr_queue
   import instr_queue_pkg::*;
#(
   parameter int DEPTH = IQ_DEPTH
) (
   input  logic     clk,
   input  logic     rst_aL,
   instr_queue_if.slave q
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic [AW-1:0] head_idx;
   logic [AW-1:0] tail_idx;
   logic          empty;
   logic          full;
   logic          enq_fire;
   logic          deq_fire;
   iq_entry_t     wr_entry;
   iq_entry_t     head_entry;

   // Entry storage is deliberately not reset; pointers alone define validity.
   iq_entry_t     mem [DEPTH];

   assign head_idx = head[AW-1:0];
   assign tail_idx = tail[AW-1:0];

   assign empty = (head == tail);
   assign full  = (head_idx == tail_idx) && (head[AW] != tail[AW]);

   assign enq_fire = q.enq_valid && !full;
   assign deq_fire = q.deq_ready && !empty;

   ptr_counter #(.W(PW)) u_tail_ptr (
      .clk    (clk),
      .rst_aL (rst_aL),
      .clear  (q.flush),
      .inc    (enq_fire),
      .ptr    (tail)
   );

   ptr_counter #(.W(PW)) u_head_ptr (
      .clk    (clk),
      .rst_aL (rst_aL),
      .clear  (q.flush),
      .inc    (deq_fire),
      .ptr    (head)
   );

   // Assemble the entry to be written at the tail
   always_comb begin
      wr_entry          = '0;
      wr_entry.instr    = q.enq_instr;
      wr_entry.pc       = q.enq_pc;
      wr_entry.npc      = q.enq_npc;
      wr_entry.br_taken = q.enq_br_taken;
   end

   // Write the accepted entry at the tail slot; a flush discards it
   always_ff @(posedge clk) begin
      if (enq_fire && !q.flush) begin
         mem[tail_idx] <= wr_entry;
      end
   end

   assign head_entry = mem[head_idx];

   assign q.enq_ready    = !full;
   assign q.deq_valid    = !empty;
   assign q.deq_instr    = head_entry.instr;
   assign q.deq_pc       = head_entry.pc;
   assign q.deq_npc      = head_entry.npc;
   assign q.deq_br_taken = head_entry.br_taken;

   // Occupancy falls out of the wrap-bit arithmetic modulo 2*DEPTH
   assign q.count = tail - head;

endmodule
